// File: rtl/ps2_key_voice.sv
// Two-voice square-wave synth with linear attack/release envelopes, mixed to one signed 16-bit sample.
// Latency: sample_out/sample_valid two cycles after sample_tick; no backpressure (ticks must be >=3 cycles apart).
module ps2_key_voice #(
    parameter int unsigned ATK_STEP = 8,
    parameter int unsigned REL_STEP = 2
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               key1_on,
    input  logic [7:0]         key1_code,
    input  logic               key2_on,
    input  logic [7:0]         key2_code,
    input  logic               sample_tick,
    output logic signed [15:0] sample_out,
    output logic               sample_valid,
    output logic [1:0]         voice_active
);

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_t;

    localparam logic [7:0] CODE_NONE = 8'hf0;
    localparam logic [8:0] ATK_INC   = 9'(ATK_STEP);
    localparam logic [8:0] REL_DEC   = 9'(REL_STEP);

    // Phase increments for C4..G5 at 48 kHz with a 16-bit accumulator
    function automatic logic [15:0] code_inc(input logic [7:0] code);
        case (code)
            8'h1c: code_inc = 16'd357;
            8'h1d: code_inc = 16'd378;
            8'h1b: code_inc = 16'd401;
            8'h24: code_inc = 16'd425;
            8'h23: code_inc = 16'd450;
            8'h2b: code_inc = 16'd477;
            8'h2c: code_inc = 16'd505;
            8'h34: code_inc = 16'd535;
            8'h35: code_inc = 16'd567;
            8'h33: code_inc = 16'd601;
            8'h3b: code_inc = 16'd636;
            8'h43: code_inc = 16'd674;
            8'h42: code_inc = 16'd714;
            8'h44: code_inc = 16'd757;
            8'h4b: code_inc = 16'd802;
            8'h4d: code_inc = 16'd850;
            8'h4c: code_inc = 16'd900;
            8'h52: code_inc = 16'd954;
            8'h5b: code_inc = 16'd1010;
            8'h15: code_inc = 16'd1070;
            default: code_inc = 16'd0;
        endcase
    endfunction

    logic [1:0]        on_meta;
    logic [1:0]        on_sync;
    logic [1:0]        on_prev;
    logic [7:0]        key_code [2];
    logic signed [9:0] voice_val [2];
    logic [1:0]        active;
    logic signed [9:0] mix_sum;
    logic              tick_d;

    assign key_code[0] = key1_code;
    assign key_code[1] = key2_code;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            on_meta <= 2'b00;
            on_sync <= 2'b00;
            on_prev <= 2'b00;
        end else begin
            on_meta <= {key2_on, key1_on};
            on_sync <= on_meta;
            on_prev <= on_sync;
        end
    end

    for (genvar v = 0; v < 2; v++) begin : g_voice
        env_t        state_q, state_d;
        logic [7:0]  amp_q, amp_d;
        logic [7:0]  code_q, code_d;
        logic [15:0] phase_q;
        logic [8:0]  amp_up, amp_dn;
        logic        pressed;

        // Code is only trusted once the synced key has been high two cycles
        assign pressed = on_sync[v] & on_prev[v] & (code_inc(key_code[v]) != 16'd0);
        assign amp_up  = {1'b0, amp_q} + ATK_INC;
        assign amp_dn  = {1'b0, amp_q} - REL_DEC;

        always_comb begin
            state_d = state_q;
            amp_d   = amp_q;
            code_d  = code_q;
            case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_d = ATTACK;
                        code_d  = key_code[v];
                    end
                end
                ATTACK: begin
                    if (sample_tick)
                        amp_d = amp_up[8] ? 8'd255 : amp_up[7:0];
                    if (!pressed) begin
                        state_d = RELEASE;
                    end else begin
                        code_d = key_code[v];
                        if (sample_tick && (amp_up[8] || amp_up[7:0] == 8'hff))
                            state_d = SUSTAIN;
                    end
                end
                SUSTAIN: begin
                    if (!pressed)
                        state_d = RELEASE;
                    else
                        code_d = key_code[v];
                end
                RELEASE: begin
                    if (sample_tick)
                        amp_d = amp_dn[8] ? 8'd0 : amp_dn[7:0];
                    // Retrigger resumes the ramp from the current amplitude
                    if (pressed) begin
                        state_d = ATTACK;
                        code_d  = key_code[v];
                    end else if (sample_tick && (amp_dn[8] || amp_dn[7:0] == 8'd0)) begin
                        state_d = IDLE;
                        code_d  = CODE_NONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge sys_clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                amp_q   <= 8'd0;
                code_q  <= CODE_NONE;
                phase_q <= 16'd0;
            end else begin
                state_q <= state_d;
                amp_q   <= amp_d;
                code_q  <= code_d;
                if (sample_tick)
                    phase_q <= phase_q + code_inc(code_q);
            end
        end

        assign active[v]    = (state_q != IDLE);
        assign voice_val[v] = (state_q == IDLE) ? 10'sd0 :
                              phase_q[15] ? -$signed({2'b00, amp_q}) : $signed({2'b00, amp_q});
    end

    assign mix_sum      = voice_val[0] + voice_val[1];
    assign voice_active = active;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tick_d       <= 1'b0;
            sample_valid <= 1'b0;
            sample_out   <= 16'sd0;
        end else begin
            tick_d       <= sample_tick;
            sample_valid <= tick_d;
            if (tick_d)
                sample_out <= {mix_sum, 6'b000000};
        end
    end

endmodule
